// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: bridges the d16 core memory port to a req/ack word-wide RAM bus,
// with byte-lane steering, a per-transaction timeout and a one-word read buffer.
module mem_bus_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              write_enable_i,
  input  logic              byte_enable_i,
  input  logic              byte_select_i,
  input  logic [15:0]       addr_i,
  input  logic [15:0]       data_in_i,
  output logic [15:0]       data_out_o,
  output logic              mem_wait_o,
  output logic              bus_err_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [1:0]        ram_be_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [15:0]       ram_wdata_o,
  input  logic              ram_ack_i,
  input  logic [15:0]       ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  // The abort fires on the TIMEOUT-th edge after REQ entry, i.e. when the count is one short.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [15:0]         buf_data_q, buf_data_d;
  logic [15:0]         data_out_q, data_out_d;
  logic                bus_err_q, bus_err_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [1:0]          ram_be_q, ram_be_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [15:0]         ram_wdata_q, ram_wdata_d;

  logic                hit;
  logic                capture;
  logic                ack_evt;
  logic                timeout_evt;
  logic                wr_to_buf;
  logic [1:0]          req_lanes;

  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[15:ADDR_W];
    end
  endgenerate

  function automatic logic [15:0] extract(input logic [15:0] word, input logic [1:0] lanes);
    case (lanes)
      2'b10:   return {8'h00, word[15:8]};
      2'b01:   return {8'h00, word[7:0]};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = REQ;
      REQ:     if (ack_evt || timeout_evt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_lanes   = !byte_enable_i ? 2'b11 : (byte_select_i ? 2'b10 : 2'b01);
    hit         = (state_q == IDLE) && en_i && !write_enable_i && buf_valid_q &&
                  (addr_i[ADDR_W-1:0] == buf_addr_q);
    capture     = (state_q == IDLE) && en_i && !hit;
    ack_evt     = (state_q == REQ) && ram_ack_i;
    timeout_evt = (state_q == REQ) && !ram_ack_i && (cnt_q == CntLast);
    wr_to_buf   = ram_we_q && (ram_addr_q == buf_addr_q);
    mem_wait_o  = (state_q == REQ) || capture;
  end

  always_comb begin
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    data_out_d  = data_out_q;
    bus_err_d   = bus_err_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (hit) begin
      data_out_d = extract(buf_data_q, req_lanes);
    end

    if (capture) begin
      ram_req_d   = 1'b1;
      ram_we_d    = write_enable_i;
      ram_be_d    = req_lanes;
      ram_addr_d  = addr_i[ADDR_W-1:0];
      ram_wdata_d = byte_enable_i ? {data_in_i[7:0], data_in_i[7:0]} : data_in_i;
      cnt_d       = 16'd0;
    end

    if (state_q == REQ) begin
      cnt_d = cnt_q + 16'd1;
      if (ack_evt || timeout_evt) begin
        ram_req_d = 1'b0;
        ram_we_d  = 1'b0;
        cnt_d     = 16'd0;
        if (wr_to_buf) buf_valid_d = 1'b0;
      end
      if (ack_evt && !ram_we_q) begin
        buf_valid_d = 1'b1;
        buf_addr_d  = ram_addr_q;
        buf_data_d  = ram_rdata_i;
        data_out_d  = extract(ram_rdata_i, ram_be_q);
      end
      if (timeout_evt) begin
        bus_err_d = 1'b1;
        if (!ram_we_q) data_out_d = 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 16'd0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= 16'd0;
      data_out_q  <= 16'd0;
      bus_err_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 2'b00;
      ram_addr_q  <= '0;
      ram_wdata_q <= 16'd0;
    end else begin
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      data_out_q  <= data_out_d;
      bus_err_q   <= bus_err_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign data_out_o  = data_out_q;
  assign bus_err_o   = bus_err_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_be_o    = ram_be_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed vector table, hand-written corner sequences, and random
// traffic checked against a buffer-plus-RAM reference model.
module tb_mem_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, write_enable, byte_enable, byte_select;
  logic [15:0] addr, data_in;
  logic [15:0] data_out;
  logic        mem_wait, bus_err;
  logic        ram_req, ram_we;
  logic [1:0]  ram_be;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic [15:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(15), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .en_i(en), .write_enable_i(write_enable), .byte_enable_i(byte_enable),
    .byte_select_i(byte_select), .addr_i(addr), .data_in_i(data_in),
    .data_out_o(data_out), .mem_wait_o(mem_wait), .bus_err_o(bus_err),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_ack_i(ram_ack), .ram_rdata_i(ram_rdata)
  );

  typedef struct {
    logic        we, be, bs;
    logic [15:0] addr, wdata, rdata;
    int          ackDelay;
    int          expStalls, expBus;
    logic [1:0]  expBe;
    logic [14:0] expAddr;
    logic [15:0] expWdata, expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] laneView(input logic [15:0] w, input logic be, input logic bs);
    if (!be) return w;
    return bs ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  // Runs one core request end to end; the RAM acks in REQ cycle ackDelay (never if >= TO).
  task automatic applyStimulus(input logic we, be, bs, input logic [15:0] a, d, rdata,
                               input int ackDelay, output int stalls, output int busCycles,
                               output int holdErr, output logic weSeen, output logic [1:0] beSeen,
                               output logic [14:0] addrSeen, output logic [15:0] wdSeen);
    stalls = 0; busCycles = 0; holdErr = 0;
    weSeen = 1'b0; beSeen = 2'b00; addrSeen = 15'd0; wdSeen = 16'd0;
    en = 1'b1; write_enable = we; byte_enable = be; byte_select = bs; addr = a; data_in = d;
    #1;
    if (!mem_wait) begin
      @(posedge clk); #1;
      if (ram_req) busCycles = 1;
      en = 1'b0;
    end else begin
      stalls = 1;
      @(posedge clk); #1;
      if (ram_req) busCycles = 1;
      weSeen = ram_we; beSeen = ram_be; addrSeen = ram_addr; wdSeen = ram_wdata;
      for (int k = 0; k < 20; k++) begin
        {en, write_enable, byte_enable, byte_select} = 4'($urandom);
        addr = 16'($urandom); data_in = 16'($urandom);
        ram_ack   = (k == ackDelay);
        ram_rdata = (k == ackDelay) ? rdata : 16'($urandom);
        #1;
        if (mem_wait) stalls++;
        if (ram_req && (ram_we !== weSeen || ram_be !== beSeen ||
                        ram_addr !== addrSeen || ram_wdata !== wdSeen)) holdErr++;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        if (!ram_req) break;
      end
      en = 1'b1; write_enable = 1'b0; addr = 16'($urandom);
      #1;
      if (mem_wait) stalls++;
      @(posedge clk); #1;
      if (ram_req) busCycles++;
      en = 1'b0;
    end
  endtask

  int          stalls, busCycles, holdErr, reqCnt, waitCnt;
  logic        weSeen;
  logic [1:0]  beSeen;
  logic [14:0] addrSeen;
  logic [15:0] wdSeen;

  logic        mBufValid, mBusErr;
  logic [14:0] mBufAddr;
  logic [15:0] mBufData, mDataOut;
  logic [15:0] ramMem[8];
  logic        rWe, rBe, rBs, expHit;
  logic [15:0] rAddr, rData, rRd;
  logic [2:0]  idx;
  int          rDelay;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    vecs[0] = '{1'b0,1'b0,1'b0,16'h0010,16'h0000,16'hBEEF, 2, 4,1,2'b11,15'h0010,16'h0000,16'hBEEF,1'b0};
    vecs[1] = '{1'b0,1'b1,1'b1,16'h0010,16'h0000,16'h0000, 0, 0,0,2'b00,15'h0000,16'h0000,16'h00BE,1'b0};
    vecs[2] = '{1'b1,1'b1,1'b0,16'h0010,16'h1234,16'h0000, 0, 2,1,2'b01,15'h0010,16'h3434,16'h00BE,1'b0};
    vecs[3] = '{1'b0,1'b0,1'b0,16'h0010,16'h0000,16'hBE34, 1, 3,1,2'b11,15'h0010,16'h0000,16'hBE34,1'b0};
    vecs[4] = '{1'b0,1'b0,1'b0,16'h0020,16'h0000,16'h0000,99, 5,1,2'b11,15'h0020,16'h0000,16'hFFFF,1'b1};
    vecs[5] = '{1'b0,1'b1,1'b0,16'h0010,16'h0000,16'h0000, 0, 0,0,2'b00,15'h0000,16'h0000,16'h0034,1'b1};
    vecs[6] = '{1'b1,1'b0,1'b0,16'h8010,16'hABCD,16'h0000, 3, 5,1,2'b11,15'h0010,16'hABCD,16'h0034,1'b1};
    vecs[7] = '{1'b0,1'b1,1'b1,16'h0010,16'h0000,16'hABCD, 0, 2,1,2'b10,15'h0010,16'h0000,16'h00AB,1'b1};

    rst = 1'b1; en = 1'b0; write_enable = 1'b0; byte_enable = 1'b0; byte_select = 1'b0;
    addr = 16'd0; data_in = 16'd0; ram_ack = 1'b0; ram_rdata = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_out", data_out, 16'h0000);
    checkOutput("rst_ram_req", ram_req, 1'b0);
    checkOutput("rst_ram_we", ram_we, 1'b0);
    checkOutput("rst_ram_be", ram_be, 2'b00);
    checkOutput("rst_ram_addr", ram_addr, 15'h0000);
    checkOutput("rst_ram_wdata", ram_wdata, 16'h0000);
    checkOutput("rst_bus_err", bus_err, 1'b0);
    checkOutput("rst_mem_wait", mem_wait, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].be, vecs[i].bs, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].ackDelay, stalls, busCycles, holdErr, weSeen, beSeen, addrSeen, wdSeen);
      checkOutput($sformatf("vec%0d_stalls", i), stalls, vecs[i].expStalls);
      checkOutput($sformatf("vec%0d_bus", i), busCycles, vecs[i].expBus);
      checkOutput($sformatf("vec%0d_hold", i), holdErr, 0);
      checkOutput($sformatf("vec%0d_data_out", i), data_out, vecs[i].expData);
      checkOutput($sformatf("vec%0d_bus_err", i), bus_err, vecs[i].expErr);
      if (vecs[i].expBus == 1) begin
        checkOutput($sformatf("vec%0d_be", i), beSeen, vecs[i].expBe);
        checkOutput($sformatf("vec%0d_addr", i), addrSeen, vecs[i].expAddr);
        checkOutput($sformatf("vec%0d_we", i), weSeen, vecs[i].we);
        if (vecs[i].we) checkOutput($sformatf("vec%0d_wdata", i), wdSeen, vecs[i].expWdata);
      end
    end

    // Constant read held on en: one bus transaction, then buffer hits.
    en = 1'b1; write_enable = 1'b0; byte_enable = 1'b0; byte_select = 1'b0;
    addr = 16'h0040; ram_rdata = 16'h5A5A; reqCnt = 0; waitCnt = 0;
    for (int c = 0; c < 10; c++) begin
      ram_ack = ram_req;
      #1;
      if (mem_wait) waitCnt++;
      if (ram_req) reqCnt++;
      @(posedge clk); #1;
    end
    ram_ack = 1'b0; en = 1'b0;
    checkOutput("held_req_cycles", reqCnt, 1);
    checkOutput("held_wait_cycles", waitCnt, 2);
    checkOutput("held_data_out", data_out, 16'h5A5A);

    // Reset in the second REQ cycle, then a late ack.
    en = 1'b1; write_enable = 1'b0; byte_enable = 1'b0; addr = 16'h0050;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ram_req", ram_req, 1'b0);
    checkOutput("abort_ram_we", ram_we, 1'b0);
    checkOutput("abort_ram_be", ram_be, 2'b00);
    checkOutput("abort_ram_addr", ram_addr, 15'h0000);
    checkOutput("abort_ram_wdata", ram_wdata, 16'h0000);
    checkOutput("abort_data_out", data_out, 16'h0000);
    checkOutput("abort_bus_err", bus_err, 1'b0);
    checkOutput("abort_mem_wait", mem_wait, 1'b0);
    rst = 1'b0; ram_ack = 1'b1; ram_rdata = 16'h1234;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    checkOutput("late_ack_req", ram_req, 1'b0);
    checkOutput("late_ack_data", data_out, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h7777, 0,
                  stalls, busCycles, holdErr, weSeen, beSeen, addrSeen, wdSeen);
    checkOutput("post_rst_miss_bus", busCycles, 1);
    checkOutput("post_rst_miss_data", data_out, 16'h7777);

    // Random traffic against the reference model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mBufValid = 1'b0; mBufAddr = 15'd0; mBufData = 16'd0; mDataOut = 16'd0; mBusErr = 1'b0;
    for (int j = 0; j < 8; j++) ramMem[j] = 16'($urandom);
    for (int i = 0; i < 300; i++) begin
      rWe = ($urandom_range(0, 2) == 0);
      rBe = 1'($urandom); rBs = 1'($urandom);
      rAddr = {1'($urandom), 12'h000, 3'($urandom)};
      rData = 16'($urandom);
      rDelay = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, TO - 1);
      idx = rAddr[2:0];
      rRd = ramMem[idx];
      expHit = !rWe && mBufValid && (mBufAddr == rAddr[14:0]);
      applyStimulus(rWe, rBe, rBs, rAddr, rData, rRd, rDelay,
                    stalls, busCycles, holdErr, weSeen, beSeen, addrSeen, wdSeen);
      checkOutput("rnd_stalls", stalls, expHit ? 0 : ((rDelay >= TO) ? TO + 1 : rDelay + 2));
      checkOutput("rnd_bus", busCycles, expHit ? 0 : 1);
      checkOutput("rnd_hold", holdErr, 0);
      if (!expHit) begin
        checkOutput("rnd_we", weSeen, rWe);
        checkOutput("rnd_be", beSeen, !rBe ? 2'b11 : (rBs ? 2'b10 : 2'b01));
        checkOutput("rnd_addr", addrSeen, rAddr[14:0]);
        if (rWe) checkOutput("rnd_wdata", wdSeen, rBe ? {rData[7:0], rData[7:0]} : rData);
      end
      if (expHit) begin
        mDataOut = laneView(mBufData, rBe, rBs);
      end else if (rDelay < TO) begin
        if (rWe) begin
          if (!rBe)     ramMem[idx] = rData;
          else if (rBs) ramMem[idx][15:8] = rData[7:0];
          else          ramMem[idx][7:0] = rData[7:0];
          if (mBufAddr == rAddr[14:0]) mBufValid = 1'b0;
        end else begin
          mBufValid = 1'b1; mBufAddr = rAddr[14:0]; mBufData = rRd;
          mDataOut = laneView(rRd, rBe, rBs);
        end
      end else begin
        mBusErr = 1'b1;
        if (rWe) begin
          if (mBufAddr == rAddr[14:0]) mBufValid = 1'b0;
        end else begin
          mDataOut = 16'hFFFF;
        end
      end
      checkOutput("rnd_data_out", data_out, mDataOut);
      checkOutput("rnd_bus_err", bus_err, mBusErr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory bus controller between the d16 core's memory port and the external word-wide RAM bus. It accepts word/byte read and write requests from the core, runs a req/ack transaction on the RAM side, and stretches the core with `mem_wait`. It steers byte lanes and bounds every transaction with a timeout. A one-entry read buffer returns repeated reads of the same word without a bus cycle.

## Interface
- `ADDR_W`, 15, RAM word-address width; core `addr[ADDR_W-1:0]` is used and upper bits are ignored.
- `TIMEOUT`, 255, maximum cycles in `REQ` before abort; 1..65535.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  core request valid; may be held high continuously.
- `write_enable`  in  1  1 = write, 0 = read.
- `byte_enable`  in  1  1 = byte access, 0 = word access.
- `byte_select`  in  1  byte lane for byte access: 0 = [7:0], 1 = [15:8].
- `addr`  in  16  word address.
- `data_in`  in  16  write data; byte writes use `data_in[7:0]`.
- `data_out`  out  16  read data to core; registered.
- `mem_wait`  out  1  core must hold request and stall; combinational.
- `bus_err`  out  1  sticky timeout flag; cleared only by `rst`.
- `ram_req`  out  1  bus request; registered.
- `ram_we`  out  1  bus write strobe; registered.
- `ram_be`  out  2  lane enables {hi,lo}; registered.
- `ram_addr`  out  ADDR_W  bus word address; registered.
- `ram_wdata`  out  16  bus write data; registered.
- `ram_ack`  in  1  bus completion; read data valid in the same cycle.
- `ram_rdata`  in  16  bus read data.

## Operation
- States: `IDLE`, `REQ`, `DONE`.
- `IDLE`, `en=0`: no action.
- `IDLE`, `en=1`, read, `buf_valid`, `addr` equals `buf_addr`: hit. No bus cycle and `mem_wait=0`. At the edge, `data_out` is loaded from the buffered word with lane extraction applied. Stay in `IDLE`.
- `IDLE`, `en=1`, any other request (write or read miss): capture `addr`, `we` and lanes, then go to `REQ`. Set `ram_req=1` at the same edge.
- Lane rules:
  - Word access: `ram_be=2'b11`.
  - Byte access: `ram_be=2'b10` if `byte_select=1`, else `2'b01`.
  - Byte writes: `ram_wdata={data_in[7:0],data_in[7:0]}`.
  - Word writes: `ram_wdata=data_in`.
- `REQ`:
  - A timeout counter increments each cycle.
  - On `ram_ack=1`: drop `ram_req`/`ram_we`, go to `DONE`, clear the counter.
  - If read: load `buf_addr`, set `buf_valid=1`, store the full `ram_rdata` word in the buffer, and load `data_out` with lane extraction.
- Lane extraction on read: word → `ram_rdata`; byte → `{8'h00, selected byte}` (zero-extended).
- Write completing to `buf_addr`: clear `buf_valid`. A write to any other address leaves the buffer intact.
- Timeout: counter reaches `TIMEOUT` without ack.
  - Drop `ram_req`, set `bus_err=1`, and set `data_out=16'hFFFF` for reads.
  - Leave `buf_valid` unchanged, except a timed-out write to `buf_addr` clears it.
  - Go to `DONE`.
- `DONE`: one cycle with `mem_wait=0`, so the core consumes the result; return to `IDLE`. A new request is not captured in `DONE`.
- `mem_wait = (state==REQ) | (state==IDLE & en & ~hit)`.
- Core inputs are sampled only at capture. Changes while in `REQ` are ignored.

## Timing
- Reset values:
  - `data_out=0`, `ram_req=0`, `ram_we=0`, `ram_be=0`, `ram_addr=0`, `ram_wdata=0`.
  - `bus_err=0`, `buf_valid=0`, state `IDLE`, counter 0.
- `rst` in any state, including mid-`REQ`, aborts immediately. `ram_req` is low from the next cycle; no `bus_err`.
- Miss / write, zero-wait RAM (ack in first `REQ` cycle), edges E0 capture, E1 ack:
  - `mem_wait` is high during the E0 cycle and the `REQ` cycle.
  - `data_out` is valid after E1; `DONE` follows.
  - Total: 2 stall cycles + 1 `DONE` cycle.
- Each extra RAM wait cycle adds exactly 1 stall cycle.
- Hit: 0 stall cycles. `data_out` is valid after the capturing edge.
- `ram_req` holds with constant `ram_addr`/`ram_we`/`ram_be`/`ram_wdata` until the ack edge or the timeout edge.
- Timeout with `TIMEOUT=N`: abort at the Nth edge after `REQ` entry.
- `ram_ack` outside `REQ` is ignored.

## Test plan
- Word read miss, `addr=16'h0010`, RAM returns `16'hBEEF` with 2 wait cycles → `ram_be=11`, `mem_wait` high 4 cycles, `data_out=16'hBEEF`.
- Byte read of the same address with `byte_select=1` immediately after → hit: no `ram_req`, `mem_wait=0`, `data_out=16'h00BE`.
- Byte write `data_in=16'h1234`, `byte_select=0`, `addr=16'h0010` → `ram_we=1`, `ram_be=01`, `ram_wdata=16'h3434`. Next read of `16'h0010` is a miss (a bus cycle occurs).
- Read with no ack, `TIMEOUT=4` → `ram_req` drops after 4 `REQ` cycles; `bus_err=1`, `data_out=16'hFFFF`. The next request proceeds normally and `bus_err` stays 1.
- `rst` asserted in the 2nd `REQ` cycle → all outputs return to reset values next cycle; a late `ram_ack` is ignored.
- `en` held high with `addr` constant after a read → exactly one bus transaction, then hits every cycle.
